// File: rtl/pool_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// pool_pkg: shared types and elaboration-time helpers for pooling blocks
// Rev 1.0
// ----------------------------------------------------------------------
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ofm_size(input int ifm, input int k, input int s);
    return (ifm - k) / s + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------
// pool_line_buffer: one-lane raster line buffer exposing a flat KxK window
// Rev 1.0
// ----------------------------------------------------------------------
module pool_line_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 28,
  parameter int KERNEL_SIZE = 2
) (
  input  logic                                          clk,
  input  logic                                          shift_en,
  input  logic [DATA_WIDTH-1:0]                         data_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window
);
  localparam int FIFO_SIZE = (KERNEL_SIZE - 1) * IFM_SIZE + KERNEL_SIZE;

  // Entry 0 is the pixel being presented; only the older entries need storage.
  logic [DATA_WIDTH-1:0] sr [FIFO_SIZE-1];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      sr[0] <= data_in;
      for (int n = 1; n < FIFO_SIZE - 1; n++) begin
        sr[n] <= sr[n-1];
      end
    end
  end

  for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_row
    for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_col
      localparam int ENTRY = j * IFM_SIZE + i;
      if (ENTRY == 0) begin : g_newest
        assign window[(j*KERNEL_SIZE+i)*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end else begin : g_stored
        assign window[(j*KERNEL_SIZE+i)*DATA_WIDTH +: DATA_WIDTH] = sr[ENTRY-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_stream_engine.sv
`default_nettype none
// ----------------------------------------------------------------------
// pool_stream_engine: streaming KxK avg/max pooling over NUM_CH lanes
// Rev 1.0
// ----------------------------------------------------------------------
module pool_stream_engine
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 28,
  parameter int KERNEL_SIZE = 2,
  parameter int STRIDE      = 2,
  parameter int NUM_CH      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         pool_mode,
  input  logic                         in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         frame_done
);
  localparam int OFM_SIZE = ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE);
  localparam int LOG_K    = clog2(KERNEL_SIZE);
  localparam int SUM_W    = DATA_WIDTH + 2 * LOG_K;
  localparam int WIN_W    = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
  localparam int CNT_W    = (IFM_SIZE > 1) ? clog2(IFM_SIZE) : 1;
  localparam int PH_W     = (STRIDE > 1) ? clog2(STRIDE) : 1;
  localparam int LAST_POS = (KERNEL_SIZE - 1) + (OFM_SIZE - 1) * STRIDE;

  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(IFM_SIZE - 1);
  localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] PH_SYNC  = CNT_W'(KERNEL_SIZE - 2);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(LAST_POS);
  localparam logic [PH_W-1:0]  PH_END   = PH_W'(STRIDE - 1);

  logic [CNT_W-1:0] col, row;
  logic [PH_W-1:0]  col_ph, row_ph;
  pool_mode_e       mode_q;

  logic       col_last, row_last, frame_start, fire, fire_last;
  pool_mode_e frame_mode;

  logic [WIN_W-1:0]             lane_win [NUM_CH];
  logic                         s1_valid, s1_last;
  pool_mode_e                   s1_mode;
  logic [WIN_W-1:0]             s1_win [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0] reduced;

  always_comb begin
    col_last    = (col == CNT_END);
    row_last    = (row == CNT_END);
    frame_start = (row == '0) && (col == '0);
    frame_mode  = frame_start ? pool_mode_e'(pool_mode) : mode_q;
    // Phase counters are zero exactly on stride-aligned window corners.
    fire        = in_valid && (row >= WIN_FIRST) && (col >= WIN_FIRST)
                  && (row_ph == '0) && (col_ph == '0);
    fire_last   = fire && (row == WIN_LAST) && (col == WIN_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
      mode_q <= POOL_AVG;
    end else if (clear) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
      mode_q <= POOL_AVG;
    end else if (in_valid) begin
      col <= col_last ? '0 : col + CNT_W'(1);
      if (col == PH_SYNC || col_ph == PH_END) col_ph <= '0;
      else                                    col_ph <= col_ph + PH_W'(1);
      if (col_last) begin
        row <= row_last ? '0 : row + CNT_W'(1);
        if (row == PH_SYNC || row_ph == PH_END) row_ph <= '0;
        else                                    row_ph <= row_ph + PH_W'(1);
      end
      if (frame_start) mode_q <= pool_mode_e'(pool_mode);
    end
  end

  // Mode travels with each window so a new frame cannot retarget in-flight ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= POOL_AVG;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= POOL_AVG;
    end else begin
      s1_valid <= fire;
      s1_last  <= fire_last;
      if (fire) s1_mode <= frame_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      for (int c = 0; c < NUM_CH; c++) begin
        s1_win[c] <= lane_win[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    logic signed [SUM_W-1:0]      sum;
    logic signed [DATA_WIDTH-1:0] tap;
    logic signed [DATA_WIDTH-1:0] max_val;
    logic        [DATA_WIDTH-1:0] result;

    pool_line_buffer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .IFM_SIZE    (IFM_SIZE),
      .KERNEL_SIZE (KERNEL_SIZE)
    ) u_line_buffer (
      .clk      (clk),
      .shift_en (in_valid),
      .data_in  (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .window   (lane_win[c])
    );

    always_comb begin
      sum     = '0;
      tap     = '0;
      max_val = s1_win[c][DATA_WIDTH-1:0];
      for (int t = 0; t < KERNEL_SIZE * KERNEL_SIZE; t++) begin
        tap = s1_win[c][t*DATA_WIDTH +: DATA_WIDTH];
        sum = sum + SUM_W'(tap);
        if (tap > max_val) max_val = tap;
      end
      // Arithmetic shift floors toward -inf, e.g. -2.5 becomes -3.
      result = (s1_mode == POOL_MAX) ? max_val : DATA_WIDTH'(sum >>> (2 * LOG_K));
    end

    assign reduced[c*DATA_WIDTH +: DATA_WIDTH] = result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else begin
      out_valid  <= s1_valid;
      frame_done <= s1_valid && s1_last;
      if (s1_valid) data_out <= reduced;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_stream_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------
// tb_pool_stream_engine: directed vectors over three engine configurations
// Rev 1.0
// ----------------------------------------------------------------------
module tb_pool_stream_engine;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          pool_mode = 1'b0;
  logic          iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic [DW-1:0] din0 = '0;
  logic [2*DW-1:0] din_a;
  logic          ov_a, fd_a, ov_b, fd_b, ov_c, fd_c;
  logic [2*DW-1:0] dout_a;
  logic [DW-1:0] dout_b, dout_c;

  assign din_a = {din0 + DW'(100), din0};

  always #5 clk = ~clk;

  // A: IFM=4 S=2 two lanes; B: IFM=3 S=1; C: IFM=5 S=2
  pool_stream_engine #(.DATA_WIDTH(DW), .IFM_SIZE(4), .KERNEL_SIZE(2), .STRIDE(2), .NUM_CH(2)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .pool_mode(pool_mode), .in_valid(iv_a),
    .data_in(din_a), .out_valid(ov_a), .data_out(dout_a), .frame_done(fd_a));
  pool_stream_engine #(.DATA_WIDTH(DW), .IFM_SIZE(3), .KERNEL_SIZE(2), .STRIDE(1), .NUM_CH(1)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .pool_mode(pool_mode), .in_valid(iv_b),
    .data_in(din0), .out_valid(ov_b), .data_out(dout_b), .frame_done(fd_b));
  pool_stream_engine #(.DATA_WIDTH(DW), .IFM_SIZE(5), .KERNEL_SIZE(2), .STRIDE(2), .NUM_CH(1)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .pool_mode(pool_mode), .in_valid(iv_c),
    .data_in(din0), .out_valid(ov_c), .data_out(dout_c), .frame_done(fd_c));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int sel = 0;
  int stray = 0;
  int ifm_of [3] = '{4, 3, 5};
  int str_of [3] = '{2, 1, 2};

  int got_v0[$], got_v1[$], got_cyc[$];
  bit got_done[$];
  int exp_val[$], exp_cyc[$];
  bit exp_done[$];

  logic m_ov, m_fd;
  logic signed [DW-1:0] m_v0, m_v1;

  always_comb begin
    m_ov = ov_c; m_fd = fd_c; m_v0 = dout_c; m_v1 = '0;
    if (sel == 0) begin
      m_ov = ov_a; m_fd = fd_a; m_v0 = dout_a[DW-1:0]; m_v1 = dout_a[2*DW-1:DW];
    end else if (sel == 1) begin
      m_ov = ov_b; m_fd = fd_b; m_v0 = dout_b;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_ov) begin
      got_v0.push_back(int'(m_v0));
      got_v1.push_back(int'(m_v1));
      got_cyc.push_back(cyc);
      got_done.push_back(m_fd);
    end
    if ((sel != 0 && ov_a) || (sel != 1 && ov_b) || (sel != 2 && ov_c) || (m_fd && !m_ov))
      stray++;
  end

  typedef struct {
    int dut;
    bit mode;
    int pat;
    bit gaps;
    int e0, e1, e2, e3;
  } vec_t;
  vec_t vecs [10];

  task automatic cmp(input string tag, input string what, input int idx, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s %s[%0d]: got %0d, expected %0d", tag, what, idx, got, exp);
    end
  endtask

  task automatic set_iv(input int d, input logic v);
    iv_a = (d == 0) && v;
    iv_b = (d == 1) && v;
    iv_c = (d == 2) && v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      set_iv(0, 1'b0);
    end
  endtask

  function automatic int pix(input int pat, input int idx, input int r, input int c);
    if (pat == 0) return idx;
    return (r < 2 && c < 2) ? -(r * 2 + c + 1) : 0;
  endfunction

  // Pixel (0,0) carries the wanted mode; every later pixel shows the opposite one.
  task automatic run_frame(input int d, input bit mode, input int pat, input bit gaps, input int npix);
    int ifm, s, ofm, r, c;
    ifm = ifm_of[d];
    s   = str_of[d];
    ofm = (ifm - 2) / s + 1;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / ifm;
      c = idx % ifm;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          set_iv(d, 1'b0);
          din0 = DW'($urandom);
          pool_mode = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      set_iv(d, 1'b1);
      din0 = DW'(pix(pat, idx, r, c));
      pool_mode = (idx == 0) ? mode : ~mode;
      if (r >= 1 && c >= 1 && (r - 1) % s == 0 && (c - 1) % s == 0
          && (r - 1) / s < ofm && (c - 1) / s < ofm) begin
        exp_cyc.push_back(cyc + 2);
        exp_done.push_back(((r - 1) / s == ofm - 1) && ((c - 1) / s == ofm - 1));
      end
    end
  endtask

  task automatic check_results(input string tag);
    int n;
    cmp(tag, "count", -1, got_v0.size(), exp_cyc.size());
    n = (got_v0.size() < exp_cyc.size()) ? got_v0.size() : exp_cyc.size();
    if (exp_val.size() < n) n = exp_val.size();
    for (int i = 0; i < n; i++) begin
      cmp(tag, "lane0", i, got_v0[i], exp_val[i]);
      if (sel == 0) cmp(tag, "lane1", i, got_v1[i], exp_val[i] + 100);
      cmp(tag, "cycle", i, got_cyc[i], exp_cyc[i]);
      cmp(tag, "done", i, int'(got_done[i]), int'(exp_done[i]));
    end
    cmp(tag, "stray", -1, stray, 0);
    got_v0.delete(); got_v1.delete(); got_cyc.delete(); got_done.delete();
    exp_val.delete(); exp_cyc.delete(); exp_done.delete();
    stray = 0;
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    exp_val.push_back(a); exp_val.push_back(b); exp_val.push_back(c); exp_val.push_back(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          dut mode pat gaps  expected outputs
    vecs[0] = '{0, 1'b0, 0, 1'b0,  2,  4, 10, 12};
    vecs[1] = '{0, 1'b1, 0, 1'b0,  5,  7, 13, 15};
    vecs[2] = '{0, 1'b0, 0, 1'b1,  2,  4, 10, 12};
    vecs[3] = '{0, 1'b1, 0, 1'b1,  5,  7, 13, 15};
    vecs[4] = '{0, 1'b0, 1, 1'b0, -3,  0,  0,  0};
    vecs[5] = '{0, 1'b1, 1, 1'b0, -1,  0,  0,  0};
    vecs[6] = '{1, 1'b0, 0, 1'b0,  2,  3,  5,  6};
    vecs[7] = '{1, 1'b1, 0, 1'b1,  4,  5,  7,  8};
    vecs[8] = '{2, 1'b0, 0, 1'b0,  3,  5, 13, 15};
    vecs[9] = '{2, 1'b1, 1, 1'b1, -1,  0,  0,  0};

    repeat (2) @(negedge clk);
    cmp("reset", "out_valid_a", -1, int'(ov_a), 0);
    cmp("reset", "data_out_a", -1, int'(dout_a), 0);
    cmp("reset", "frame_done_a", -1, int'(fd_a), 0);
    cmp("reset", "out_valid_b", -1, int'(ov_b), 0);
    cmp("reset", "data_out_c", -1, int'(dout_c), 0);
    reset = 1'b1;
    idle(2);

    for (int v = 0; v < 10; v++) begin
      sel = vecs[v].dut;
      push4(vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3);
      run_frame(vecs[v].dut, vecs[v].mode, vecs[v].pat, vecs[v].gaps,
                ifm_of[vecs[v].dut] * ifm_of[vecs[v].dut]);
      idle(4);
      check_results($sformatf("vec%0d", v));
    end

    // Clear one cycle after the second window fires: that window must vanish.
    sel = 0;
    exp_val.push_back(2);
    run_frame(0, 1'b0, 0, 1'b0, 8);
    void'(exp_cyc.pop_back());
    void'(exp_done.pop_back());
    @(negedge clk);
    set_iv(0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cmp("clear", "out_valid", -1, int'(ov_a), 0);
    cmp("clear", "data_out", -1, int'(dout_a), 0);
    idle(3);
    check_results("clear_partial");
    push4(2, 4, 10, 12);
    run_frame(0, 1'b0, 0, 1'b0, 16);
    idle(4);
    check_results("after_clear");

    // Reset after pixel 9 of a MAX frame, then a fresh frame.
    exp_val.push_back(5);
    exp_val.push_back(7);
    run_frame(0, 1'b1, 0, 1'b0, 10);
    @(negedge clk);
    set_iv(0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    cmp("midreset", "out_valid", -1, int'(ov_a), 0);
    cmp("midreset", "data_out", -1, int'(dout_a), 0);
    cmp("midreset", "frame_done", -1, int'(fd_a), 0);
    reset = 1'b1;
    idle(3);
    check_results("reset_partial");
    push4(5, 7, 13, 15);
    run_frame(0, 1'b1, 0, 1'b0, 16);
    idle(4);
    check_results("after_reset");

    // Back-to-back frames with a mode switch on the second frame's first pixel.
    push4(2, 4, 10, 12);
    push4(5, 7, 13, 15);
    run_frame(0, 1'b0, 0, 1'b0, 16);
    run_frame(0, 1'b1, 0, 1'b0, 16);
    idle(4);
    check_results("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
